bpc_plane_rebuild: RTL and testbench

- Parametrised successor to the bit-plane decompressor back end.
- Accepts one base word plus a stream of decoded DBX symbols (one bit-plane per beat) from the symbol decoder group.
- Rebuilds the delta bit-planes (with XOR un-chaining) and reconstructs original words by true running-prefix summation.
- Emits the block LANES words per beat over a full valid/ready output; generalised in word width, block length and output lanes.

---
 rtl/bpc_plane_rebuild_pkg.sv | 27 ++
 rtl/bpc_plane_rebuild_prefix_lane.sv | 32 +++
 rtl/bpc_plane_rebuild.sv | 190 +++++++++++++++++++
 tb/tb_bpc_plane_rebuild.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpc_plane_rebuild_pkg.sv
// bpc_pkg: shared FSM state type and sizing helpers for the bit-plane rebuild back end.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package bpc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLANES = 2'd1,
    EMIT   = 2'd2
  } state_e;

  // Number of output beats needed to carry one block.
  function automatic int beat_count(input int n, input int lanes);
    return n / lanes;
  endfunction

  // Plane counter must be able to hold 0..w.
  function automatic int pcnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Beat counter holds 0..n/lanes-1; keep at least one bit when a block is a single beat.
  function automatic int bcnt_width(input int n, input int lanes);
    return ((n / lanes) > 1) ? $clog2(n / lanes) : 1;
  endfunction

endpackage

// File: rtl/bpc_plane_rebuild_prefix_lane.sv
// bpc_prefix_lane: LANES-deep chained modular adder producing one beat of rebuilt words.
// Latency: combinational.
// Backpressure: none; the caller holds acc_i/delta_i stable while the beat is stalled.
// Ports: acc_i last word emitted (or base on the first beat), delta_i lane i at [i*W +: W],
//        first_i suppresses the lane-0 add, words_o word i at the MSB end, acc_o last word of beat.
module bpc_prefix_lane #(
  parameter int W     = 16,
  parameter int LANES = 4
) (
  input  logic [W-1:0]       acc_i,
  input  logic [LANES*W-1:0] delta_i,
  input  logic               first_i,
  output logic [LANES*W-1:0] words_o,
  output logic [W-1:0]       acc_o
);

  logic [W-1:0] run;

  always_comb begin
    run     = acc_i;
    words_o = '0;
    for (int i = 0; i < LANES; i++) begin
      // On the first beat lane 0 is the base word itself; there is no delta in front of it.
      if (!(first_i && (i == 0))) begin
        run = run + delta_i[i*W +: W];
      end
      words_o[(LANES-1-i)*W +: W] = run;
    end
    acc_o = run;
  end

endmodule

// File: rtl/bpc_plane_rebuild.sv
// bpc_plane_rebuild: rebuilds delta bit-planes (XOR un-chaining) and prefix-sums them into words.
// Latency: first beat valid the cycle after the terminating symbol; N/LANES back-to-back beats.
// Backpressure: full valid/ready on the output; beat, sop and eop hold while out_ready_o is low.
// Ports: base_* takes one base word (IDLE only), sym_* takes one decoded plane per beat
//        (PLANES only), out_* emits LANES words per beat (lowest index in MSBs), err_len_o flags
//        a W-th plane without sym_last. Optional macro BPC_REBUILD_STATS_EN adds blk_cnt_o and
//        stall_cnt_o counters.
module bpc_plane_rebuild
  import bpc_pkg::*;
#(
  parameter int W     = 16,
  parameter int N     = 64,
  parameter int LANES = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               base_valid_i,
  output logic               base_ready_o,
  input  logic [W-1:0]       base_word_i,
  input  logic               sym_valid_i,
  output logic               sym_ready_o,
  input  logic [N-2:0]       sym_dbx_i,
  input  logic               sym_xor_i,
  input  logic               sym_last_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [LANES*W-1:0] out_data_o,
  output logic               out_sop_o,
  output logic               out_eop_o,
  output logic               err_len_o
`ifdef BPC_REBUILD_STATS_EN
  ,
  output logic [31:0]        blk_cnt_o,
  output logic [31:0]        stall_cnt_o
`endif
);

  localparam int NB = beat_count(N, LANES);
  localparam int PW = pcnt_width(W);
  localparam int BW = bcnt_width(N, LANES);
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  state_e         state_q, state_d;
  logic [N-2:0]   plane_q [W];
  logic [N-2:0]   plane_d [W];
  logic [PW-1:0]  pcnt_q, pcnt_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;
  logic [W-1:0]   acc_q, acc_d;
  logic           err_q, err_d;

  logic               last_beat;
  logic [IW-1:0]      pidx;
  logic [LANES*W-1:0] delta_flat;
  logic [LANES*W-1:0] beat_words;
  logic [W-1:0]       acc_next;
  int                 dk;
  logic [N-2:0]       dsh;

  assign base_ready_o = (state_q == IDLE);
  assign sym_ready_o  = (state_q == PLANES);
  assign out_valid_o  = (state_q == EMIT);
  assign last_beat    = (bcnt_q == BW'(NB - 1));
  assign pidx         = pcnt_q[IW-1:0];

  // Transpose planes into per-word deltas for this beat. Lane i carries delta[k] with
  // k = beat*LANES + i - 1, i.e. the step from the previous word to word beat*LANES+i.
  always_comb begin
    delta_flat = '0;
    dk         = 0;
    dsh        = '0;
    for (int i = 0; i < LANES; i++) begin
      dk = int'(bcnt_q) * LANES + i - 1;
      if (dk >= 0) begin
        for (int j = 0; j < W; j++) begin
          // Plane j is delta bit W-1-j; delta index k sits at plane bit N-2-k.
          dsh = plane_q[j] >> (N - 2 - dk);
          delta_flat[i*W + (W-1-j)] = dsh[0];
        end
      end
    end
  end

  bpc_prefix_lane #(
    .W     (W),
    .LANES (LANES)
  ) u_prefix (
    .acc_i   (acc_q),
    .delta_i (delta_flat),
    .first_i (bcnt_q == '0),
    .words_o (beat_words),
    .acc_o   (acc_next)
  );

  always_comb begin
    state_d = state_q;
    plane_d = plane_q;
    pcnt_d  = pcnt_q;
    bcnt_d  = bcnt_q;
    acc_d   = acc_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (base_valid_i) begin
          acc_d = base_word_i;
          for (int j = 0; j < W; j++) begin
            plane_d[j] = '0;
          end
          pcnt_d  = '0;
          bcnt_d  = '0;
          state_d = PLANES;
        end
      end
      PLANES: begin
        if (sym_valid_i) begin
          if ((pcnt_q != '0) && sym_xor_i) begin
            plane_d[pidx] = sym_dbx_i ^ plane_q[pidx - IW'(1)];
          end else begin
            plane_d[pidx] = sym_dbx_i;
          end
          pcnt_d = pcnt_q + PW'(1);
          if (sym_last_i || (pcnt_q == PW'(W - 1))) begin
            bcnt_d  = '0;
            state_d = EMIT;
          end
          err_d = (pcnt_q == PW'(W - 1)) && !sym_last_i;
        end
      end
      EMIT: begin
        if (out_ready_i) begin
          // acc only advances on a handshake so a stalled beat recomputes identically.
          acc_d = acc_next;
          if (last_beat) begin
            bcnt_d  = '0;
            state_d = IDLE;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      for (int j = 0; j < W; j++) begin
        plane_q[j] <= '0;
      end
      pcnt_q <= '0;
      bcnt_q <= '0;
      acc_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      plane_q <= plane_d;
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  assign out_data_o = out_valid_o ? beat_words : '0;
  assign out_sop_o  = out_valid_o && (bcnt_q == '0);
  assign out_eop_o  = out_valid_o && last_beat;
  assign err_len_o  = err_q;

`ifdef BPC_REBUILD_STATS_EN
  logic [31:0] blk_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blk_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (out_valid_o && out_ready_i && last_beat) begin
        blk_cnt_q <= blk_cnt_q + 32'd1;
      end
      if (out_valid_o && !out_ready_i) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign blk_cnt_o   = blk_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bpc_plane_rebuild.sv
module tb_bpc_plane_rebuild;

  localparam int NB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        base_valid, base_ready;
  logic [15:0] base_word;
  logic        sym_valid, sym_ready, sym_xor, sym_last;
  logic [62:0] sym_dbx;
  logic        out_valid, out_ready, out_sop, out_eop, err_len;
  logic [63:0] out_data;

  logic         b_base_valid, b_base_ready;
  logic [31:0]  b_base_word;
  logic         b_sym_valid, b_sym_ready, b_sym_xor, b_sym_last;
  logic [30:0]  b_sym_dbx;
  logic         b_out_valid, b_out_ready, b_out_sop, b_out_eop, b_err_len;
  logic [255:0] b_out_data;

`ifdef BPC_REBUILD_STATS_EN
  logic [31:0] blk_cnt, stall_cnt, b_blk_cnt, b_stall_cnt;
`endif

  bpc_plane_rebuild #(.W(16), .N(64), .LANES(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .base_valid_i(base_valid), .base_ready_o(base_ready), .base_word_i(base_word),
    .sym_valid_i(sym_valid), .sym_ready_o(sym_ready), .sym_dbx_i(sym_dbx),
    .sym_xor_i(sym_xor), .sym_last_i(sym_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_sop_o(out_sop), .out_eop_o(out_eop), .err_len_o(err_len)
`ifdef BPC_REBUILD_STATS_EN
    , .blk_cnt_o(blk_cnt), .stall_cnt_o(stall_cnt)
`endif
  );

  bpc_plane_rebuild #(.W(32), .N(32), .LANES(8)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .base_valid_i(b_base_valid), .base_ready_o(b_base_ready), .base_word_i(b_base_word),
    .sym_valid_i(b_sym_valid), .sym_ready_o(b_sym_ready), .sym_dbx_i(b_sym_dbx),
    .sym_xor_i(b_sym_xor), .sym_last_i(b_sym_last),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .out_sop_o(b_out_sop), .out_eop_o(b_out_eop), .err_len_o(b_err_len)
`ifdef BPC_REBUILD_STATS_EN
    , .blk_cnt_o(b_blk_cnt), .stall_cnt_o(b_stall_cnt)
`endif
  );

  typedef struct {
    logic [15:0]       base;
    int                np;
    logic [15:0][62:0] p;
    logic [15:0]       xr;
    logic              last;
    logic [15:0]       w0, w1, w2, w63;
    logic              err;
  } vec_t;

  vec_t        vt [7];
  logic [15:0] words [64];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          err_seen = 0;
  int          to_bad = 0;

  always @(negedge clk) if (err_len === 1'b1) err_seen++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one block into dut and collects its beats; stall_mode toggles out_ready.
  task automatic run_block(input vec_t v, input bit stall_mode, input string tag);
    int          cyc, beats, se_bad, st_bad;
    logic [63:0] pd;
    logic        ps, pe, pstall, rdy;
    err_seen = 0;
    @(negedge clk);
    base_valid = 1'b1; base_word = v.base; cyc = 0;
    while (base_ready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    if (cyc >= 50) to_bad++;
    @(negedge clk);
    base_valid = 1'b0;
    for (int s = 0; s < v.np; s++) begin
      sym_valid = 1'b1; sym_dbx = v.p[s]; sym_xor = v.xr[s];
      sym_last = v.last && (s == v.np - 1);
      cyc = 0;
      while (sym_ready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
      if (cyc >= 50) to_bad++;
      @(negedge clk);
    end
    sym_valid = 1'b0; sym_last = 1'b0; sym_xor = 1'b0; sym_dbx = '0;
    check({tag, "_latency_valid"}, out_valid, 1'b1);
    check({tag, "_err_timing"}, err_len, v.err);
    beats = 0; cyc = 0; se_bad = 0; st_bad = 0; pstall = 1'b0; rdy = 1'b1;
    pd = '0; ps = 1'b0; pe = 1'b0;
    while (beats < NB && cyc < 200) begin
      out_ready = rdy;
      if (out_valid === 1'b1) begin
        if (pstall && (out_data !== pd || out_sop !== ps || out_eop !== pe)) st_bad++;
        if (out_sop !== (beats == 0) || out_eop !== (beats == NB - 1)) se_bad++;
        pd = out_data; ps = out_sop; pe = out_eop;
        if (rdy) begin
          for (int i = 0; i < 4; i++) words[beats*4 + i] = out_data[(3-i)*16 +: 16];
          beats++;
        end
        pstall = !rdy;
      end
      if (stall_mode) rdy = !rdy;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    check({tag, "_beats"}, beats, NB);
    check({tag, "_sop_eop_bad"}, se_bad, 0);
    check({tag, "_stall_hold_bad"}, st_bad, 0);
    check({tag, "_idle_valid"}, out_valid, 1'b0);
    check({tag, "_idle_base_ready"}, base_ready, 1'b1);
    check({tag, "_err_count"}, err_seen, v.err ? 1 : 0);
    check({tag, "_w0"}, words[0], v.w0);
    check({tag, "_w1"}, words[1], v.w1);
    check({tag, "_w2"}, words[2], v.w2);
    check({tag, "_w63"}, words[63], v.w63);
  endtask

  initial begin
    int          cyc, nv;
    logic [255:0] expb;
`ifdef BPC_REBUILD_STATS_EN
    logic [31:0] s0, b0;
`endif
    // ---------------- vector table ----------------
    for (int r = 0; r < 7; r++) begin
      vt[r].base = '0; vt[r].np = 1; vt[r].p = '0; vt[r].xr = '0; vt[r].last = 1'b1;
      vt[r].w0 = '0; vt[r].w1 = '0; vt[r].w2 = '0; vt[r].w63 = '0; vt[r].err = 1'b0;
    end
    // single zero plane: every word equals the base
    vt[0].base = 16'h1234; vt[0].w0 = 16'h1234; vt[0].w1 = 16'h1234; vt[0].w2 = 16'h1234; vt[0].w63 = 16'h1234;
    // 16 planes, LSB plane all ones: delta 1 per word, wraps past 0xFFFF
    vt[1].base = 16'hFFFE; vt[1].np = 16; vt[1].p[15] = 63'h7FFF_FFFF_FFFF_FFFF;
    vt[1].w0 = 16'hFFFE; vt[1].w1 = 16'hFFFF; vt[1].w2 = 16'h0000; vt[1].w63 = 16'h003D;
    // XOR rebuild: plane1 = 0 ^ plane0 = all ones, delta 0xC000
    vt[2].np = 2; vt[2].p[0] = 63'h7FFF_FFFF_FFFF_FFFF; vt[2].xr[1] = 1'b1;
    vt[2].w1 = 16'hC000; vt[2].w2 = 16'h8000; vt[2].w63 = 16'h4000;
    // only delta[0] bit 15 set
    vt[3].base = 16'h0001; vt[3].p[0] = 63'h4000_0000_0000_0000;
    vt[3].w0 = 16'h0001; vt[3].w1 = 16'h8001; vt[3].w2 = 16'h8001; vt[3].w63 = 16'h8001;
    // only delta[62] bit 14 set: lands in the very last word
    vt[4].base = 16'h0010; vt[4].np = 2; vt[4].p[1] = 63'h1;
    vt[4].w0 = 16'h0010; vt[4].w1 = 16'h0010; vt[4].w2 = 16'h0010; vt[4].w63 = 16'h4010;
    // 16 planes without sym_last: err_len pulse, block still emitted
    vt[5].base = 16'h0BAD; vt[5].np = 16; vt[5].last = 1'b0; vt[5].err = 1'b1;
    vt[5].w0 = 16'h0BAD; vt[5].w1 = 16'h0BAD; vt[5].w2 = 16'h0BAD; vt[5].w63 = 16'h0BAD;
    // XOR chain over three planes: delta0=0xC000, delta1=0x2000
    vt[6].np = 3; vt[6].xr = 16'h0007;
    vt[6].p[0] = 63'h4000_0000_0000_0000; vt[6].p[1] = 63'h0;
    vt[6].p[2] = 63'h6000_0000_0000_0000;
    vt[6].w1 = 16'hC000; vt[6].w2 = 16'hE000; vt[6].w63 = 16'hE000;

    // ---------------- reset ----------------
    rst = 1'b1;
    base_valid = 0; base_word = '0; sym_valid = 0; sym_dbx = '0; sym_xor = 0; sym_last = 0; out_ready = 1;
    b_base_valid = 0; b_base_word = '0; b_sym_valid = 0; b_sym_dbx = '0; b_sym_xor = 0; b_sym_last = 0; b_out_ready = 1;
    repeat (3) @(negedge clk);
    check("rst_base_ready", base_ready, 1'b1);
    check("rst_sym_ready", sym_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sop_eop", {out_sop, out_eop}, 2'b00);
    check("rst_err_len", err_len, 1'b0);
    check("rst_out_data", out_data, 64'h0);
`ifdef BPC_REBUILD_STATS_EN
    check("rst_blk_cnt", blk_cnt, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    rst = 1'b0;

    // ---------------- table-driven blocks ----------------
    for (int r = 0; r < 7; r++) begin
      run_block(vt[r], 1'b0, $sformatf("vec%0d", r));
    end

    // ---------------- stalled output ----------------
`ifdef BPC_REBUILD_STATS_EN
    s0 = stall_cnt; b0 = blk_cnt;
`endif
    run_block(vt[2], 1'b1, "stall");
`ifdef BPC_REBUILD_STATS_EN
    check("stall_cnt_delta", stall_cnt - s0, 32'd15);
    check("blk_cnt_delta", blk_cnt - b0, 32'd1);
`endif

    // ---------------- reset in the middle of EMIT ----------------
    @(negedge clk);
    base_valid = 1'b1; base_word = 16'h5A5A; cyc = 0;
    while (base_ready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    if (cyc >= 50) to_bad++;
    @(negedge clk);
    base_valid = 1'b0; sym_valid = 1'b1; sym_dbx = '0; sym_last = 1'b1;
    @(negedge clk);
    sym_valid = 1'b0; sym_last = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_pre_valid", out_valid, 1'b1);
    check("midrst_pre_sop", out_sop, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_base_ready", base_ready, 1'b1);
    check("midrst_sym_ready", sym_ready, 1'b0);
    nv = 0;
    repeat (20) begin @(negedge clk); if (out_valid === 1'b1) nv++; end
    check("midrst_no_beats", nv, 0);
    run_block(vt[3], 1'b0, "postrst");

    // ---------------- W=32, N=32, LANES=8: words 0..31 ----------------
    @(negedge clk);
    b_base_valid = 1'b1; b_base_word = '0; cyc = 0;
    while (b_base_ready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    if (cyc >= 50) to_bad++;
    @(negedge clk);
    b_base_valid = 1'b0;
    for (int s = 0; s < 32; s++) begin
      b_sym_valid = 1'b1; b_sym_xor = 1'b0;
      b_sym_dbx = (s == 31) ? 31'h7FFF_FFFF : 31'h0;
      b_sym_last = (s == 31);
      cyc = 0;
      while (b_sym_ready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
      if (cyc >= 50) to_bad++;
      @(negedge clk);
    end
    b_sym_valid = 1'b0; b_sym_last = 1'b0;
    for (int b = 0; b < 4; b++) begin
      cyc = 0;
      while (b_out_valid !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
      if (cyc >= 50) to_bad++;
      expb = '0;
      for (int i = 0; i < 8; i++) expb[(7-i)*32 +: 32] = 32'(b*8 + i);
      check($sformatf("w32_beat%0d_data", b), b_out_data, expb);
      check($sformatf("w32_beat%0d_sop_eop", b), {b_out_sop, b_out_eop}, {b == 0, b == 3});
      @(negedge clk);
    end
    check("w32_idle", {b_out_valid, b_base_ready}, 2'b01);

    check("handshake_timeouts", to_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
